// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I load/store funct3 codes, FSM states
// and the funct3 legality check.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  localparam funct3_e F3_SB = F3_LB;
  localparam funct3_e F3_SH = F3_LH;
  localparam funct3_e F3_SW = F3_LW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE1 = 3'd1,
    S_WAIT1  = 3'd2,
    S_ISSUE2 = 3'd3,
    S_WAIT2  = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  // Stores have no unsigned variants, so only the three sized codes are legal for them.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (funct3_e'(f3))
      F3_LB, F3_LH, F3_LW: return 1'b1;
      F3_LBU, F3_LHU:      return !we;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: per-beat byte enables and store data,
// split detection and load data assembly/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        beat2,
  input  logic [31:0] wdata,
  input  logic [31:0] beat0,
  input  logic [31:0] beat1,
  output logic        split,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  output logic [31:0] rdata
);

  logic [3:0]  mask;
  logic [5:0]  sh;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] rd_word;

  always_comb begin
    sh = {1'b0, off, 3'b000};
    case (funct3[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    split = ((funct3[1:0] == 2'b01) && (off == 2'b11)) ||
            ((funct3[1:0] == 2'b10) && (off != 2'b00));
    // The upper half of each widened shift is exactly what spills into the second word.
    be_wide   = {4'b0000, mask} << off;
    wd_wide   = {32'h0, wdata} << sh;
    be        = beat2 ? be_wide[7:4] : be_wide[3:0];
    bus_wdata = beat2 ? wd_wide[63:32] : wd_wide[31:0];
    rd_word   = 32'({beat1, beat0} >> sh);
    case (funct3_e'(funct3))
      F3_LB:   rdata = {{24{rd_word[7]}}, rd_word[7:0]};
      F3_LH:   rdata = {{16{rd_word[15]}}, rd_word[15:0]};
      F3_LW:   rdata = rd_word;
      F3_LBU:  rdata = {24'h0, rd_word[7:0]};
      F3_LHU:  rdata = {16'h0, rd_word[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// Load/store unit bus master: accepts one CPU access at a time and issues it as
// one or two word-aligned bus beats, returning extended load data.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  state_e                state;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [31:0]           beat0_q;
  logic [31:0]           beat1_q;
  logic                  legal;
  logic                  split;
  logic                  second;
  logic [31:0]           ld_data;
  logic [ADDR_WIDTH-1:0] base;

  assign legal  = f3_legal(we_q, f3_q);
  assign second = (state == S_ISSUE2) || (state == S_WAIT2);
  assign base   = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  lsu_align u_align (
    .funct3    (f3_q),
    .off       (addr_q[1:0]),
    .beat2     (second),
    .wdata     (wdata_q),
    .beat0     (beat0_q),
    .beat1     (beat1_q),
    .split     (split),
    .be        (mem_be),
    .bus_wdata (mem_wdata),
    .rdata     (ld_data)
  );

  assign req_ready  = (state == S_IDLE);
  assign mem_req    = (state == S_ISSUE1) || (state == S_ISSUE2);
  assign mem_we     = we_q;
  assign mem_addr   = second ? base + ADDR_WIDTH'(4) : base;
  assign resp_valid = (state == S_RESP);
  assign resp_err   = resp_valid && !legal;
  assign resp_rdata = (resp_valid && legal && !we_q) ? ld_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat0_q <= '0;
      beat1_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            beat0_q <= '0;
            beat1_q <= '0;
            state   <= f3_legal(req_we, req_funct3) ? S_ISSUE1 : S_RESP;
          end
        end
        S_ISSUE1: if (mem_gnt) state <= S_WAIT1;
        S_WAIT1: begin
          if (mem_rvalid) begin
            beat0_q <= mem_rdata;
            state   <= split ? S_ISSUE2 : S_RESP;
          end
        end
        S_ISSUE2: if (mem_gnt) state <= S_WAIT2;
        S_WAIT2: begin
          if (mem_rvalid) begin
            beat1_q <= mem_rdata;
            state   <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master: a bus responder records each granted beat and
// returns table data one cycle after grant; each access is checked against hand values.
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // responder state
  int unsigned nb = 0;
  int unsigned hold_cnt = 0;
  logic        no_rvalid = 1'b0;
  logic        inject_rvalid = 1'b0;
  logic [31:0] rd_tbl [2];
  logic [31:0] b_addr [4];
  logic [31:0] b_be   [4];
  logic [31:0] b_wd   [4];
  logic [31:0] b_we   [4];
  logic [31:0] exp_hold_addr = 32'h0;
  logic [31:0] exp_hold_be = 32'h0;
  logic [31:0] exp_hold_wd = 32'h0;

  lsu_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Bus responder: grant decided mid-cycle, rvalid one cycle after the grant edge.
  initial begin : responder
    logic        granted;
    int unsigned gidx;
    gidx = 0;
    forever begin
      @(negedge clk);
      granted = 1'b0;
      if (mem_req && hold_cnt > 0) begin
        chk("hold_addr", mem_addr, exp_hold_addr);
        chk("hold_be", {28'h0, mem_be}, exp_hold_be);
        chk("hold_wdata", mem_wdata, exp_hold_wd);
        chk("hold_we", {31'h0, mem_we}, 32'h1);
        mem_gnt = 1'b0;
        hold_cnt--;
      end else begin
        mem_gnt = mem_req;
        granted = mem_req;
      end
      if (granted) begin
        if (nb < 4) begin
          b_addr[nb] = mem_addr;
          b_be[nb]   = {28'h0, mem_be};
          b_wd[nb]   = mem_wdata;
          b_we[nb]   = {31'h0, mem_we};
        end
        gidx = nb;
        nb++;
      end
      @(posedge clk);
      #1;
      mem_rvalid    = (granted && !no_rvalid) || inject_rvalid;
      inject_rvalid = 1'b0;
      mem_rdata     = granted ? rd_tbl[(gidx < 2) ? gidx : 1] : 32'h0BAD0BAD;
    end
  end

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int unsigned lat, input int unsigned beats,
                        input logic [31:0] rdata, input logic err);
    int unsigned cyc;
    logic        seen;
    nb = 0;
    @(negedge clk);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (resp_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    chk({tag, "_lat"}, seen ? cyc : 32'hFFFF, lat);
    chk({tag, "_rdata"}, resp_rdata, rdata);
    chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, err});
    chk({tag, "_beats"}, nb, beats);
    @(posedge clk);
    #1;
    chk({tag, "_1cyc"}, {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned rv_cnt;
    rd_tbl[0] = 32'h0;
    rd_tbl[1] = 32'h0;

    // reset values while rst_n is held low
    #13;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // aligned lw
    rd_tbl[0] = 32'hDEADBEEF;
    do_req("lw_al", 1'b0, 3'b010, 32'h00010000, 32'h0, 3, 1, 32'hDEADBEEF, 1'b0);
    chk("lw_al_addr", b_addr[0], 32'h00010000);
    chk("lw_al_be", b_be[0], 32'hF);
    chk("lw_al_we", b_we[0], 32'h0);

    // lb / lbu on the top byte
    rd_tbl[0] = 32'h80112233;
    do_req("lb", 1'b0, 3'b000, 32'h00010003, 32'h0, 3, 1, 32'hFFFFFF80, 1'b0);
    chk("lb_be", b_be[0], 32'h8);
    chk("lb_addr", b_addr[0], 32'h00010000);
    do_req("lbu", 1'b0, 3'b100, 32'h00010003, 32'h0, 3, 1, 32'h00000080, 1'b0);

    // lh at offset 1, bytes 0x5A,0xA5 -> sign extended
    rd_tbl[0] = 32'h11A55A22;
    do_req("lh1", 1'b0, 3'b001, 32'h00010001, 32'h0, 3, 1, 32'hFFFFA55A, 1'b0);
    chk("lh1_be", b_be[0], 32'h6);

    // split sw at offset 2
    do_req("sw_sp", 1'b1, 3'b010, 32'h00010002, 32'hAABBCCDD, 5, 2, 32'h0, 1'b0);
    chk("sw_sp_addr0", b_addr[0], 32'h00010000);
    chk("sw_sp_be0", b_be[0], 32'hC);
    chk("sw_sp_wd0", b_wd[0], 32'hCCDD0000);
    chk("sw_sp_addr1", b_addr[1], 32'h00010004);
    chk("sw_sp_be1", b_be[1], 32'h3);
    chk("sw_sp_wd1", b_wd[1], 32'h0000AABB);
    chk("sw_sp_we1", b_we[1], 32'h1);

    // split lhu at offset 3
    rd_tbl[0] = 32'h44A1B2C3;
    rd_tbl[1] = 32'h0F0E0D55;
    do_req("lhu_sp", 1'b0, 3'b101, 32'h00010003, 32'h0, 5, 2, 32'h00005544, 1'b0);
    chk("lhu_sp_be0", b_be[0], 32'h8);
    chk("lhu_sp_be1", b_be[1], 32'h1);
    chk("lhu_sp_addr1", b_addr[1], 32'h00010004);

    // split lw at offset 1
    rd_tbl[0] = 32'hAABBCCDD;
    rd_tbl[1] = 32'h11223344;
    do_req("lw_sp", 1'b0, 3'b010, 32'h00010001, 32'h0, 5, 2, 32'h44AABBCC, 1'b0);
    chk("lw_sp_be0", b_be[0], 32'hE);
    chk("lw_sp_be1", b_be[1], 32'h1);

    // sh to 0xFC goes to the bus like any address
    do_req("sh_fc", 1'b1, 3'b001, 32'h000000FC, 32'h1234BEEF, 3, 1, 32'h0, 1'b0);
    chk("sh_fc_addr", b_addr[0], 32'h000000FC);
    chk("sh_fc_be", b_be[0], 32'h3);
    chk("sh_fc_wd", b_wd[0], 32'h1234BEEF);

    // grant withheld three cycles
    exp_hold_addr = 32'h00020004;
    exp_hold_be   = 32'hF;
    exp_hold_wd   = 32'h5A5AA5A5;
    hold_cnt      = 3;
    do_req("sw_hold", 1'b1, 3'b010, 32'h00020004, 32'h5A5AA5A5, 6, 1, 32'h0, 1'b0);
    chk("sw_hold_left", hold_cnt, 32'h0);
    chk("sw_hold_wd", b_wd[0], 32'h5A5AA5A5);

    // illegal funct3 codes
    do_req("ld_011", 1'b0, 3'b011, 32'h00010000, 32'h0, 1, 0, 32'h0, 1'b1);
    do_req("st_100", 1'b1, 3'b100, 32'h00010000, 32'hFFFFFFFF, 1, 0, 32'h0, 1'b1);

    // reset while waiting for the first beat, then a stray rvalid
    nb        = 0;
    no_rvalid = 1'b1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h00030000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_granted", nb, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    rst_n         = 1'b1;
    no_rvalid     = 1'b0;
    inject_rvalid = 1'b1;
    rv_cnt        = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) rv_cnt++;
    end
    chk("rst_mid_no_resp", rv_cnt, 32'h0);
    chk("rst_mid_mem_req2", {31'h0, mem_req}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_master.md
LSU_MASTER -- requirements
Module: lsu_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data and bus word width; only 32 is supported.
REQ-003 SHALL have ports clk (in, 1, sole clock) and rst_n (in, 1, asynchronous active-low reset), listed first.
REQ-004 SHALL have CPU request ports: req_valid in 1; req_ready out 1; req_we in 1 (1 = store); req_funct3 in 3 (RV32I load/store funct3); req_addr in ADDR_WIDTH (byte address); req_wdata in DATA_WIDTH.
REQ-005 SHALL have CPU response ports: resp_valid out 1; resp_rdata out DATA_WIDTH (extended load data, 0 for stores); resp_err out 1 (illegal funct3).
REQ-006 SHALL have memory bus ports: mem_req out 1; mem_gnt in 1; mem_we out 1; mem_addr out ADDR_WIDTH (word-aligned, [1:0]=0); mem_be out 4; mem_wdata out 32; mem_rvalid in 1 (completion for read and write); mem_rdata in 32.

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP.
REQ-008 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both high at a clk edge, and its fields are latched.
REQ-009 SHALL treat funct3 legal as 000/001/010/100/101 for loads and 000/001/010 for stores; on an illegal code go IDLE->RESP with no bus access, resp_err=1 and resp_rdata=0.
REQ-010 SHALL classify legal accesses by offset off=addr[1:0]:
- split when the access crosses a word boundary: lh/lhu/sh with off=3, or lw/sw with off!=0
- all other accesses are single-beat.
REQ-011 SHALL, for the first beat, drive mem_addr={addr[31:2],2'b00}, mem_be=(size mask)<<off truncated to 4 bits, mem_wdata=wdata<<(8*off).
- Size masks: byte 0001, half 0011, word 1111.
REQ-012 SHALL, for the second beat, drive mem_addr=first beat address+4, mem_be=(size mask)>>(4-off), mem_wdata=wdata>>(8*(4-off)).
REQ-013 SHALL assert mem_req in ISSUE1/ISSUE2 with address, be, we and wdata held stable until mem_gnt=1; on grant, move to WAIT1/WAIT2 and drop mem_req the next cycle.
REQ-014 SHALL ignore mem_rvalid outside WAIT states.
REQ-015 SHALL, in WAIT1 on mem_rvalid, capture mem_rdata as beat0, then go to ISSUE2 if split, else RESP.
REQ-016 SHALL, in WAIT2 on mem_rvalid, capture beat1 and go to RESP.
REQ-017 SHALL assemble load data as bytes {beat1,beat0} shifted right by 8*off, then extract:
- lb: sign-extend byte
- lh: sign-extend half
- lw: word
- lbu: zero-extend byte
- lhu: zero-extend half.
REQ-018 SHALL assert resp_valid for exactly one cycle in RESP with resp_rdata/resp_err valid, then return to IDLE.
REQ-019 SHALL meet latency, with mem_gnt in the same cycle as mem_req and mem_rvalid one cycle after grant:
- aligned single-beat access: resp_valid 3 cycles after acceptance
- split access: resp_valid 5 cycles after acceptance.
REQ-020 SHALL apply no MMIO special-casing; address 0x000000FC is issued on the bus like any other address.

Reset
REQ-021 SHALL, while rst_n=0, immediately force state IDLE, mem_req=0, resp_valid=0, resp_err=0, resp_rdata=0, latched request and beat registers=0, req_ready=1.
REQ-022 SHALL, on reset mid-transaction, abandon the transaction without a response; any later mem_rvalid is ignored per REQ-014.

Structure
REQ-023 SHALL place the funct3 enum (LB, LH, LW, LBU, LHU; SB=LB, SH=LH, SW=LW) and the FSM state enum in package lsu_pkg.
REQ-024 SHALL use one combinational sub-module lsu_align that computes be/wdata per beat and the load extraction; the FSM lives in lsu_master.

Verification
REQ-025 SHALL cover aligned lw at 0x00010000 with mem_rdata=0xDEADBEEF and zero-wait memory -> one beat, be=1111, resp_rdata=0xDEADBEEF at cycle 3.
REQ-026 SHALL cover lb at 0x00010003 with mem_rdata=0x80112233 -> be=1000, resp_rdata=0xFFFFFF80; lbu at the same address -> 0x00000080.
REQ-027 SHALL cover sw at 0x00010002 with wdata=0xAABBCCDD -> beat0 addr 0x00010000, be=1100, wdata[31:16]=0xCCDD; beat1 addr 0x00010004, be=0011, wdata[15:0]=0xAABB; resp_valid at cycle 5.
REQ-028 SHALL cover lhu at 0x00010003 with beat0=0x44xxxxxx and beat1=0xxxxxxx55 -> resp_rdata=0x00005544.
REQ-029 SHALL cover mem_gnt withheld 3 cycles -> mem_req and all bus fields stable throughout; also funct3=011 -> no mem_req, resp_err=1 one cycle later.
REQ-030 SHALL cover rst_n pulsed low in WAIT1 -> mem_req=0 and req_ready=1 immediately; a late mem_rvalid produces no resp_valid.
